// File: rtl/sdram_stream_feeder.sv
// Paces a buffered write stream and counted read requests into single-command SDRAM controller slots.
// Optional SDRAM_FEEDER_STATS_EN adds free-running write/read command counters.
module sdram_stream_feeder #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 16,
    parameter int RDCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              rd_req,
    output logic              rd_req_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ctl_chip_sel,
    output logic              ctl_wr_en,
    output logic              ctl_rd_en,
    output logic [DATA_W-1:0] ctl_data_in,
    input  logic [DATA_W-1:0] ctl_data_out,
`ifdef SDRAM_FEEDER_STATS_EN
    output logic [31:0]       stat_wr_cnt,
    output logic [31:0]       stat_rd_cnt,
`endif
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, SEL, CMD, WAIT, DONE} state_t;

    state_t state, state_next;
    logic   slot_wr, slot_wr_next;   // kind of the slot in flight: 1 = write
    logic   last_wr;                 // kind served last; reset value makes writes win first

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic               full, empty, push, pop;
    logic [RDCNT_W-1:0] pend_cnt;
    logic               rd_inc, rd_dec, rd_pend;

    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty        = (wr_ptr == rd_ptr);
    assign wr_ready     = !full;
    assign push         = wr_valid && wr_ready;
    assign pop          = (state == CMD) && slot_wr;

    assign rd_pend      = (pend_cnt != '0);
    assign rd_req_ready = (pend_cnt != '1);
    assign rd_inc       = rd_req && rd_req_ready;
    assign rd_dec       = (state == CMD) && !slot_wr;

    assign busy         = (state != IDLE) || !empty || rd_pend;

    // NOTE: the storage array has no reset; only the pointers define which words are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pend_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({rd_inc, rd_dec})
                2'b10:   pend_cnt <= pend_cnt + RDCNT_W'(1);
                2'b01:   pend_cnt <= pend_cnt - RDCNT_W'(1);
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next   = state;
        slot_wr_next = slot_wr;
        case (state)
            IDLE: begin
                if (!empty || rd_pend) begin
                    state_next   = SEL;
                    slot_wr_next = (!empty && rd_pend) ? !last_wr : !empty;
                end
            end
            SEL:     state_next = CMD;
            CMD:     state_next = WAIT;
            WAIT:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            slot_wr      <= 1'b0;
            last_wr      <= 1'b0;
            ctl_chip_sel <= 1'b0;
            ctl_wr_en    <= 1'b0;
            ctl_rd_en    <= 1'b0;
            ctl_data_in  <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
        end else begin
            state        <= state_next;
            slot_wr      <= slot_wr_next;
            if (state == IDLE && state_next == SEL)
                last_wr <= slot_wr_next;
            ctl_chip_sel <= (state_next == SEL);
            ctl_wr_en    <= (state_next == CMD) && slot_wr;
            ctl_rd_en    <= (state_next == CMD) && !slot_wr;
            if (state_next == CMD && slot_wr)
                ctl_data_in <= mem[rd_ptr[AW-1:0]];
            rd_valid     <= (state == DONE) && !slot_wr;
            if (state == DONE && !slot_wr)
                rd_data <= ctl_data_out;
        end
    end

`ifdef SDRAM_FEEDER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else begin
            if (pop)
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            if (rd_dec)
                stat_rd_cnt <= stat_rd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_stream_feeder.sv
// Scoreboard bench for sdram_stream_feeder: stimulus queues expected commands/data, a negedge monitor checks them.
module tb_sdram_stream_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        rd_req = 1'b0;
    logic        rd_req_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        ctl_chip_sel, ctl_wr_en, ctl_rd_en;
    logic [15:0] ctl_data_in;
    logic [15:0] ctl_data_out = '0;
    logic        busy;
`ifdef SDRAM_FEEDER_STATS_EN
    logic [31:0] stat_wr_cnt, stat_rd_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [15:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    bit          exp_cmd[$];     // 1 = write command, 0 = read command
    logic [15:0] model_q[$];     // words the controller model returns, in order
    int          rd_cmd_cyc[$];
    int          last_cmd_cyc = 0;
    bit          have_last = 0;
    int          first_wr_cyc = -1;
    logic        prev_rd_valid = 1'b0;

    sdram_stream_feeder #(.DEPTH(8), .DATA_W(16), .RDCNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_req_ready(rd_req_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .ctl_chip_sel(ctl_chip_sel), .ctl_wr_en(ctl_wr_en), .ctl_rd_en(ctl_rd_en),
        .ctl_data_in(ctl_data_in), .ctl_data_out(ctl_data_out),
`ifdef SDRAM_FEEDER_STATS_EN
        .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: presents the next queued word on data_out after each rd_en.
    always @(posedge clk) begin
        if (ctl_rd_en && model_q.size() > 0)
            ctl_data_out <= model_q.pop_front();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ctl_wr_en || ctl_rd_en) begin
                check("wr_rd_exclusive", {31'd0, ctl_wr_en && ctl_rd_en}, 32'd0);
                if (have_last)
                    check("slot_spacing_ge4", {31'd0, (cyc - last_cmd_cyc) >= 4}, 32'd1);
                last_cmd_cyc = cyc;
                have_last = 1;
                if (exp_cmd.size() == 0)
                    flag("unexpected_cmd");
                else
                    check("cmd_order", {31'd0, ctl_wr_en}, {31'd0, exp_cmd.pop_front()});
                if (ctl_wr_en) begin
                    if (first_wr_cyc < 0)
                        first_wr_cyc = cyc;
                    if (exp_wr.size() == 0)
                        flag("unexpected_write");
                    else
                        check("wr_data_order", {16'd0, ctl_data_in}, {16'd0, exp_wr.pop_front()});
                end
                if (ctl_rd_en)
                    rd_cmd_cyc.push_back(cyc);
            end
            if (rd_valid) begin
                check("rd_valid_single_pulse", {31'd0, prev_rd_valid}, 32'd0);
                if (exp_rd.size() == 0)
                    flag("unexpected_rd_valid");
                else
                    check("rd_data", {16'd0, rd_data}, {16'd0, exp_rd.pop_front()});
                if (rd_cmd_cyc.size() == 0)
                    flag("rd_valid_without_rd_en");
                else
                    check("rd_latency", cyc - rd_cmd_cyc.pop_front(), 32'd3);
            end
            prev_rd_valid = rd_valid;
        end
    end

    // Called at a negedge; returns at the negedge after the word was accepted, wr_valid left high.
    task automatic push(input logic [15:0] d, output int stalls, output int acc_cyc);
        bit done = 0;
        stalls = 0;
        acc_cyc = -1;
        wr_data = d;
        wr_valid = 1'b1;
        exp_wr.push_back(d);
        for (int n = 0; n < 64 && !done; n++) begin
            if (wr_ready) begin
                done = 1;
                acc_cyc = cyc;
            end else begin
                stalls++;
            end
            @(negedge clk);
        end
        if (!done)
            flag("push_timeout");
    endtask

    task automatic read_req(input logic [15:0] ret, input bit expect_data);
        model_q.push_back(ret);
        if (expect_data)
            exp_rd.push_back(ret);
        check("rd_req_ready", {31'd0, rd_req_ready}, 32'd1);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            if (!busy)
                done = 1;
        end
        if (!done)
            flag("wait_idle_timeout");
    endtask

    int st, ac;
    int acc9;
    int stalls_q[9];

    initial begin
        // Reset state
        #1;
        check("rst_chip_sel", {31'd0, ctl_chip_sel}, 32'd0);
        check("rst_wr_en", {31'd0, ctl_wr_en}, 32'd0);
        check("rst_rd_en", {31'd0, ctl_rd_en}, 32'd0);
        check("rst_data_in", {16'd0, ctl_data_in}, 32'd0);
        check("rst_rd_data", {16'd0, rd_data}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_rd_req_ready", {31'd0, rd_req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single write: chip_sel at t, wr_en at t+1, busy low at t+4
        exp_cmd.push_back(1'b1);
        push(16'hA5A5, st, ac);
        wr_valid = 1'b0;
        check("sw_busy_after_push", {31'd0, busy}, 32'd1);
        check("sw_no_sel_yet", {31'd0, ctl_chip_sel}, 32'd0);
        @(negedge clk);
        check("sw_chip_sel_t", {31'd0, ctl_chip_sel}, 32'd1);
        check("sw_wr_en_not_t", {31'd0, ctl_wr_en}, 32'd0);
        @(negedge clk);
        check("sw_wr_en_t1", {31'd0, ctl_wr_en}, 32'd1);
        check("sw_data_t1", {16'd0, ctl_data_in}, 32'h0000A5A5);
        check("sw_sel_off_t1", {31'd0, ctl_chip_sel}, 32'd0);
        @(negedge clk);
        check("sw_wr_en_off_t2", {31'd0, ctl_wr_en}, 32'd0);
        check("sw_data_hold_t2", {16'd0, ctl_data_in}, 32'h0000A5A5);
        @(negedge clk);
        check("sw_busy_t3", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("sw_busy_t4", {31'd0, busy}, 32'd0);
        check("sw_fifo_not_full", {31'd0, wr_ready}, 32'd1);

        // FIFO full: read slot wins first (last served was a write), 8 words fill the FIFO
        first_wr_cyc = -1;
        exp_cmd.push_back(1'b0);
        for (int i = 0; i < 9; i++) exp_cmd.push_back(1'b1);
        model_q.push_back(16'h3333);
        exp_rd.push_back(16'h3333);
        rd_req = 1'b1;
        push(16'd1, stalls_q[0], ac);
        rd_req = 1'b0;
        for (int i = 1; i < 9; i++) begin
            push(16'(i + 1), stalls_q[i], ac);
            if (i == 8)
                acc9 = ac;
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 8; i++)
            check($sformatf("full_no_stall_w%0d", i + 1), stalls_q[i], 32'd0);
        check("full_w9_stalled_once", stalls_q[8], 32'd1);
        check("full_w9_after_first_pop", {31'd0, first_wr_cyc >= 0 && acc9 > first_wr_cyc}, 32'd1);
        wait_idle(100);

        // Single read
        exp_cmd.push_back(1'b0);
        read_req(16'h1234, 1'b1);
        wait_idle(40);
        check("sr_rd_data", {16'd0, rd_data}, 32'h00001234);
        repeat (3) @(negedge clk);
        check("sr_rd_data_hold", {16'd0, rd_data}, 32'h00001234);
        check("sr_rd_valid_low", {31'd0, rd_valid}, 32'd0);

        // Mixed contention: W,R,W,R,W,R
        for (int i = 0; i < 3; i++) begin
            exp_cmd.push_back(1'b1);
            exp_cmd.push_back(1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            model_q.push_back(16'h2001 + 16'(i));
            exp_rd.push_back(16'h2001 + 16'(i));
            exp_wr.push_back(16'h0101 * 16'(i + 1));
            check("mix_wr_ready", {31'd0, wr_ready}, 32'd1);
            check("mix_rd_req_ready", {31'd0, rd_req_ready}, 32'd1);
            wr_data = 16'h0101 * 16'(i + 1);
            wr_valid = 1'b1;
            rd_req = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rd_req = 1'b0;
        wait_idle(200);

        // Reset during the CMD cycle of a read
        begin
            bit seen = 0;
            exp_cmd.push_back(1'b0);
            read_req(16'hBEEF, 1'b0);
            for (int n = 0; n < 20 && !seen; n++) begin
                if (ctl_rd_en) seen = 1;
                else @(negedge clk);
            end
            if (!seen) flag("rst_mid_no_rd_en");
        end
        #1 reset = 1'b1;
        #1;
        check("rstmid_chip_sel", {31'd0, ctl_chip_sel}, 32'd0);
        check("rstmid_wr_en", {31'd0, ctl_wr_en}, 32'd0);
        check("rstmid_rd_en", {31'd0, ctl_rd_en}, 32'd0);
        check("rstmid_data_in", {16'd0, ctl_data_in}, 32'd0);
        check("rstmid_rd_data", {16'd0, rd_data}, 32'd0);
        check("rstmid_rd_valid", {31'd0, rd_valid}, 32'd0);
        model_q.delete();
        rd_cmd_cyc.delete();
        have_last = 0;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_busy_after", {31'd0, busy}, 32'd0);
        check("rstmid_rd_req_ready", {31'd0, rd_req_ready}, 32'd1);
        repeat (15) @(negedge clk);
        check("rstmid_still_idle", {31'd0, busy}, 32'd0);

`ifdef SDRAM_FEEDER_STATS_EN
        check("stat_wr_rst", stat_wr_cnt, 32'd0);
        check("stat_rd_rst", stat_rd_cnt, 32'd0);
        for (int i = 0; i < 5; i++) begin
            exp_cmd.push_back(1'b1);
            push(16'hC000 + 16'(i), st, ac);
        end
        wr_valid = 1'b0;
        wait_idle(200);
        for (int i = 0; i < 2; i++) begin
            exp_cmd.push_back(1'b0);
            read_req(16'hD000 + 16'(i), 1'b1);
        end
        wait_idle(200);
        repeat (2) @(negedge clk);
        check("stat_wr_cnt", stat_wr_cnt, 32'd5);
        check("stat_rd_cnt", stat_rd_cnt, 32'd2);
`endif

        repeat (2) @(negedge clk);
        check("sb_cmd_drained", exp_cmd.size(), 32'd0);
        check("sb_wr_drained", exp_wr.size(), 32'd0);
        check("sb_rd_drained", exp_rd.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
